// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA bus arbiter and channels.
package dma_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RELEASE = 2'd2} arb_state_t;
  localparam int DMA_BUS_WIDTH = 32;
  localparam int DMA_ADDR_STRIDE = 4;
endpackage

// File: rtl/dma_rr_select.sv
// dma_rr_select: combinational rotating-priority picker; first requester at or after the pointer wins.
module dma_rr_select #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  localparam int PW1 = PW + 1;
  logic [PW:0] w_pos;
  // Scan from farthest to nearest so the lowest offset from the pointer is written last.
  always_comb begin
    o_onehot = '0;
    o_idx = '0;
    o_any = |i_req;
    w_pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_pos = {1'b0, i_ptr} + PW1'(i);
      if (w_pos >= PW1'(N)) w_pos = w_pos - PW1'(N);
      if (i_req[w_pos[PW-1:0]]) begin
        o_idx = w_pos[PW-1:0];
        o_onehot = '0;
        o_onehot[w_pos[PW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin sharing of one system-bus master port among DMA channels,
// one whole request/ready/release transaction per grant.
module dma_bus_arbiter
  import dma_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [CHANNELS-1:0]               i_m_request,
  input  logic [CHANNELS-1:0]               i_m_rw,
  input  logic [DMA_BUS_WIDTH*CHANNELS-1:0] i_m_address,
  input  logic [DMA_BUS_WIDTH*CHANNELS-1:0] i_m_wdata,
  output logic [CHANNELS-1:0]               o_m_ready,
  output logic [DMA_BUS_WIDTH-1:0]          o_m_rdata,
  output logic                              o_bus_request,
  output logic                              o_bus_rw,
  output logic [DMA_BUS_WIDTH-1:0]          o_bus_address,
  output logic [DMA_BUS_WIDTH-1:0]          o_bus_wdata,
  input  logic                              i_bus_ready,
  input  logic [DMA_BUS_WIDTH-1:0]          i_bus_rdata,
  output logic [CHANNELS-1:0]               o_grant,
  output logic                              o_busy
);
  localparam int PW = $clog2(CHANNELS);
  localparam int W = DMA_BUS_WIDTH;
  arb_state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_idx, w_idx;
  logic [CHANNELS-1:0] w_onehot, r_m_ready, r_grant;
  logic w_any, r_abort, r_bus_request, r_bus_rw;
  logic [W-1:0] r_bus_address, r_bus_wdata, r_m_rdata;

  dma_rr_select #(.N(CHANNELS), .PW(PW)) u_select (
    .i_req    (i_m_request),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_any ? ACTIVE : IDLE;
      ACTIVE:  w_next = i_bus_ready ? RELEASE : ACTIVE;
      RELEASE: w_next = (!i_m_request[r_idx] && !i_bus_ready) ? IDLE : RELEASE;
      default: w_next = IDLE;
    endcase
  end

  // r_abort remembers a request dropped while ACTIVE so no upstream ready is ever issued for it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_abort <= 1'b0;
      r_bus_request <= 1'b0;
      r_bus_rw <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata <= '0;
      r_m_ready <= '0;
      r_m_rdata <= '0;
      r_grant <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_idx <= w_idx;
        r_ptr <= (w_idx == PW'(CHANNELS - 1)) ? '0 : w_idx + 1'b1;
        r_abort <= 1'b0;
        r_bus_request <= 1'b1;
        r_bus_rw <= i_m_rw[w_idx];
        r_bus_address <= i_m_address[w_idx*W +: W];
        r_bus_wdata <= i_m_wdata[w_idx*W +: W];
        r_grant <= w_onehot;
      end
    end else if (r_state == ACTIVE) begin
      if (!i_m_request[r_idx]) r_abort <= 1'b1;
      if (i_bus_ready) begin
        r_m_rdata <= i_bus_rdata;
        r_m_ready <= (r_abort || !i_m_request[r_idx]) ? '0 : r_grant;
        r_bus_request <= 1'b0;
      end
    end else if (w_next == IDLE) begin
      r_m_ready <= '0;
      r_grant <= '0;
    end
  end

  assign o_m_ready = r_m_ready;
  assign o_m_rdata = r_m_rdata;
  assign o_bus_request = r_bus_request;
  assign o_bus_rw = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata = r_bus_wdata;
  assign o_grant = r_grant;
  assign o_busy = (r_state != IDLE);
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed scenarios against a 4-channel and a 3-channel arbiter.
module tb_dma_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [3:0] req, rw, m_ready, grant;
  logic [127:0] addr, wdata;
  logic bus_ready, bus_req, bus_rw, busy;
  logic [31:0] bus_rdata, m_rdata, bus_addr, bus_wdata;
  logic [2:0] q_req, q_rw, q_m_ready, q_grant;
  logic [95:0] q_addr, q_wdata;
  logic q_bus_ready, q_bus_req, q_bus_rw, q_busy;
  logic [31:0] q_bus_rdata, q_m_rdata, q_bus_addr, q_bus_wdata;
  int n_cmp = 0;
  int n_bad = 0;

  dma_bus_arbiter #(.CHANNELS(4)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_m_request(req), .i_m_rw(rw),
    .i_m_address(addr), .i_m_wdata(wdata), .o_m_ready(m_ready), .o_m_rdata(m_rdata),
    .o_bus_request(bus_req), .o_bus_rw(bus_rw), .o_bus_address(bus_addr),
    .o_bus_wdata(bus_wdata), .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
    .o_grant(grant), .o_busy(busy)
  );

  dma_bus_arbiter #(.CHANNELS(3)) dut3 (
    .i_clock(clk), .i_reset(rst_n), .i_m_request(q_req), .i_m_rw(q_rw),
    .i_m_address(q_addr), .i_m_wdata(q_wdata), .o_m_ready(q_m_ready), .o_m_rdata(q_m_rdata),
    .o_bus_request(q_bus_req), .o_bus_rw(q_bus_rw), .o_bus_address(q_bus_addr),
    .o_bus_wdata(q_bus_wdata), .i_bus_ready(q_bus_ready), .i_bus_rdata(q_bus_rdata),
    .o_grant(q_grant), .o_busy(q_busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; rw = '0; addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    q_req = '0; q_rw = '0; q_addr = '0; q_wdata = '0; q_bus_ready = 1'b0; q_bus_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve4(input bit rereq, output logic [3:0] g, output logic [3:0] mr, output bit ok);
    int t = 0;
    ok = 1'b0; g = '0; mr = '0;
    while (!bus_req && t < 20) begin @(negedge clk); t++; end
    if (!bus_req) return;
    ok = 1'b1;
    g = grant;
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFE_0000;
    @(negedge clk);
    mr = m_ready;
    req = req & ~g;
    bus_ready = 1'b0;
    @(negedge clk);
    if (rereq) req = req | g;
  endtask

  task automatic serve3(input bit rereq, output logic [2:0] g, output bit ok);
    int t = 0;
    ok = 1'b0; g = '0;
    while (!q_bus_req && t < 20) begin @(negedge clk); t++; end
    if (!q_bus_req) return;
    ok = 1'b1;
    g = q_grant;
    q_bus_ready = 1'b1;
    @(negedge clk);
    q_req = q_req & ~g;
    q_bus_ready = 1'b0;
    @(negedge clk);
    if (rereq) q_req = q_req | g;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; rw = '0; addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    q_req = '0; q_rw = '0; q_addr = '0; q_wdata = '0; q_bus_ready = 1'b0; q_bus_rdata = '0;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL reset_m_ready got %b want 0000", m_ready); end
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({bus_addr, bus_wdata, m_rdata, bus_rw} !== '0) begin n_bad++; $display("FAIL reset_data got %h %h %h %b want 0", bus_addr, bus_wdata, m_rdata, bus_rw); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic [3:0] g, mr;
    bit ok;
    do_reset();
    req[2] = 1'b1; rw[2] = 1'b1; addr[64 +: 32] = 32'h100; wdata[64 +: 32] = 32'hDEAD;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL wr_bus_req got %b want 1", bus_req); end
    n_cmp++; if ({bus_rw, bus_addr, bus_wdata} !== {1'b1, 32'h100, 32'hDEAD}) begin n_bad++; $display("FAIL wr_bus_fields got %b %h %h want 1 100 dead", bus_rw, bus_addr, bus_wdata); end
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL wr_grant got %b want 0100", grant); end
    @(negedge clk);
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL wr_early_ready got %b want 0000", m_ready); end
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_ready !== 4'b0100) begin n_bad++; $display("FAIL wr_m_ready got %b want 0100", m_ready); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL wr_bus_req_drop got %b want 0", bus_req); end
    req[2] = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, grant, m_ready} !== 9'b0) begin n_bad++; $display("FAIL wr_idle got busy=%b grant=%b ready=%b want 0", busy, grant, m_ready); end
    n_cmp++; if (bus_addr !== 32'h100) begin n_bad++; $display("FAIL wr_addr_hold got %h want 100", bus_addr); end
    req = 4'hF;
    serve4(1'b0, g, mr, ok);
    n_cmp++; if (!ok || g !== 4'b1000) begin n_bad++; $display("FAIL wr_next_ptr got ok=%b grant=%b want 1000", ok, g); end
    req = '0;
  endtask

  task automatic test_round_robin();
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    logic [3:0] g, mr;
    bit ok;
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serve4(1'b1, g, mr, ok);
      n_cmp++; if (!ok || g !== 4'(1 << exp_ch[i])) begin n_bad++; $display("FAIL rr_grant[%0d] got ok=%b grant=%b want %b", i, ok, g, 4'(1 << exp_ch[i])); end
      n_cmp++; if (mr !== g) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, mr, g); end
    end
    req = '0;
  endtask

  task automatic test_read();
    do_reset();
    req[1] = 1'b1; rw[1] = 1'b0; addr[32 +: 32] = 32'h200;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_rw, bus_addr} !== {1'b1, 1'b0, 32'h200}) begin n_bad++; $display("FAIL rd_bus got %b %b %h want 1 0 200", bus_req, bus_rw, bus_addr); end
    bus_ready = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    n_cmp++; if (m_ready !== 4'b0010) begin n_bad++; $display("FAIL rd_m_ready got %b want 0010", m_ready); end
    n_cmp++; if (m_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rd_m_rdata got %h want 12345678", m_rdata); end
    req[1] = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    n_cmp++; if ({busy, m_ready} !== 5'b1_0010) begin n_bad++; $display("FAIL rd_release_wait got busy=%b ready=%b want 1 0010", busy, m_ready); end
    bus_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, m_ready, grant} !== 9'b0) begin n_bad++; $display("FAIL rd_idle got busy=%b ready=%b grant=%b want 0", busy, m_ready, grant); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g, mr;
    bit ok;
    do_reset();
    req[2] = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rm_active got %b want 1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus_req, m_ready, grant, busy} !== 10'b0) begin n_bad++; $display("FAIL rm_async got req=%b ready=%b grant=%b busy=%b want 0", bus_req, m_ready, grant, busy); end
    @(negedge clk);
    req = 4'b0101;
    rst_n = 1'b1;
    serve4(1'b0, g, mr, ok);
    n_cmp++; if (!ok || g !== 4'b0001) begin n_bad++; $display("FAIL rm_first_grant got ok=%b grant=%b want 0001", ok, g); end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req[3] = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL ab_grant got %b want 1000", grant); end
    req[3] = 1'b0;
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, bus_req, m_ready} !== 6'b10_0000) begin n_bad++; $display("FAIL ab_no_ready got busy=%b req=%b ready=%b want 1 0 0000", busy, bus_req, m_ready); end
    bus_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, grant, m_ready} !== 9'b0) begin n_bad++; $display("FAIL ab_idle got busy=%b grant=%b ready=%b want 0", busy, grant, m_ready); end
  endtask

  task automatic test_three_wrap();
    logic [2:0] g;
    bit ok;
    do_reset();
    q_req = 3'b010;
    serve3(1'b0, g, ok);
    n_cmp++; if (!ok || g !== 3'b010) begin n_bad++; $display("FAIL c3_setup got ok=%b grant=%b want 010", ok, g); end
    q_req = 3'b101;
    serve3(1'b1, g, ok);
    n_cmp++; if (!ok || g !== 3'b100) begin n_bad++; $display("FAIL c3_ptr2 got ok=%b grant=%b want 100", ok, g); end
    serve3(1'b0, g, ok);
    n_cmp++; if (!ok || g !== 3'b001) begin n_bad++; $display("FAIL c3_wrap got ok=%b grant=%b want 001", ok, g); end
    q_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_reset_mid();
    test_abort();
    test_three_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Round-robin arbiter that shares one system-bus master port between `CHANNELS` DMA channels. It sits between the DMA channel instances and the system interconnect. It grants one whole bus transaction (request → ready → release) at a time and rotates priority after every grant. Each channel's upstream handshake matches a plain bus slave: request held until ready, ready held until request drops.

## Interface
- `CHANNELS`, default 4: number of upstream DMA channels (2..8).
- `i_clock` in 1: system clock; all state on rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_m_request` in CHANNELS: per-channel bus request, level, held until ready seen.
- `i_m_rw` in CHANNELS: per-channel direction, 1 = write.
- `i_m_address` in 32*CHANNELS: per-channel address; channel k occupies bits [32k+31:32k].
- `i_m_wdata` in 32*CHANNELS: per-channel write data, same packing.
- `o_m_ready` out CHANNELS: per-channel ready, one-hot or zero.
- `o_m_rdata` out 32: read data, shared by all channels; valid while the granted channel's ready is high.
- `o_bus_request` out 1: downstream request.
- `o_bus_rw` out 1: downstream direction.
- `o_bus_address` out 32: downstream address.
- `o_bus_wdata` out 32: downstream write data.
- `i_bus_ready` in 1: downstream ready, level, held by the slave until request drops.
- `i_bus_rdata` in 32: downstream read data, valid with `i_bus_ready`.
- `o_grant` out CHANNELS: one-hot current owner; zero in IDLE.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACTIVE: downstream request outstanding.
  - RELEASE: waiting for both sides to drop the handshake.
- IDLE:
  - If any `i_m_request` bit is set, select the winner: the first requesting index at or after `priority_ptr`, searching with wrap-around.
  - Latch the winner's rw/address/wdata onto the `o_bus_*` outputs.
  - Set `o_bus_request`=1 and `o_grant`=onehot(winner).
  - Set `priority_ptr` = (winner+1) mod CHANNELS.
  - Go to ACTIVE.
- ACTIVE:
  - On `i_bus_ready`=1, capture `o_m_rdata` from `i_bus_rdata` (captured for writes too).
  - Set `o_m_ready[winner]`=1 and `o_bus_request`=0.
  - Go to RELEASE.
- RELEASE:
  - Hold `o_m_ready[winner]` while `i_m_request[winner]`=1.
  - When `i_m_request[winner]`=0 and `i_bus_ready`=0: clear `o_m_ready`, clear `o_grant`, go to IDLE.
- The downstream address/wdata/rw outputs stay stable from grant until the next grant.
- A channel that deasserts its request while ACTIVE is a protocol violation. The arbiter still completes the downstream transaction, then returns to IDLE through RELEASE with no upstream ready pulse.
- Fairness: a continuously requesting channel is granted within CHANNELS grants.
- `priority_ptr` is a $clog2(CHANNELS)-bit counter; wrap is explicit modulo CHANNELS (no power-of-two assumption).
- Out-of-range state decodes to IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - `priority_ptr`=0.
  - State IDLE.
- Reset mid-transaction drops the downstream request immediately (asynchronous). No upstream ready is generated.
- Latency:
  - Request seen in IDLE at cycle T → `o_bus_request` high at T+1.
  - Downstream ready at cycle R → `o_m_ready` high at R+1.
  - Minimum turnaround, upstream request to upstream ready with a zero-wait slave: 2 cycles.
- Requests arriving while ACTIVE or RELEASE wait; arbitration happens only in IDLE.
- No back-to-back grant without one IDLE cycle. Minimum cycle per transaction is 4 clocks, which bounds bus occupancy.
- Simultaneous requests are resolved in a single cycle by rotating priority. Never grant two channels at once.

## Structure
- Shared package `dma_pkg`:
  - `arb_state_t` enum (IDLE=2'd0, ACTIVE=2'd1, RELEASE=2'd2).
  - `DMA_BUS_WIDTH`=32.
  - Address-stride constant 4, shared with the channel.
- Sub-module `dma_rr_select`: combinational rotating-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, index, any-valid.
  - Verified standalone.
- Top level holds the FSM, the latched winner index, the pointer and the output registers.

## Test plan
- Single channel 2 write addr 0x100 data 0xDEAD, slave ready after 3 cycles → bus sees rw=1, 0x100, 0xDEAD; `o_m_ready[2]` high only; `priority_ptr`=3 afterwards.
- All 4 channels request continuously, pointer 0 → grant order 0,1,2,3,0; never two grant bits set.
- Channel 1 read, slave returns 0x12345678 → `o_m_rdata`=0x12345678 while `o_m_ready[1]`=1; release waits until `i_bus_ready` falls.
- Assert `i_reset`=0 during ACTIVE → `o_bus_request`, `o_m_ready`, `o_grant` all 0 immediately; after release the first grant goes to channel 0.
- Channel 3 drops its request mid-ACTIVE → downstream completes; `o_m_ready[3]` stays 0; FSM returns to IDLE.
- CHANNELS=3, pointer at 2, requests {0,2} → channel 2 granted, then channel 0 (wrap without power-of-two).
